// File: rtl/shift_seq_ctrl.sv
// Command-driven sequencer for a bidirectional shift register: accepts
// (dir, len, data) over valid/ready and drives en/dir/d for len cycles.
//
// state | meaning
// IDLE  | ready for a command, register untouched
// SHIFT | one register shift per cycle, serial bit from data_q[0]
// DONE  | one-cycle completion pulse, then back to IDLE
module shift_seq_ctrl #(
  parameter int MSB = 4,
  parameter int CW  = 3
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           cmd_valid,
  output logic           cmd_ready,
  input  logic           cmd_dir,
  input  logic [CW-1:0]  cmd_len,
  input  logic [MSB-1:0] cmd_data,
  input  logic           abort,
  output logic           sr_en,
  output logic           sr_dir,
  output logic           sr_d,
  output logic           busy,
  output logic           done,
  output logic [CW-1:0]  shifted
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic           dir_q;
  logic [MSB-1:0] data_q;
  logic [CW-1:0]  rem_q;
  logic [CW-1:0]  shifted_q;
  logic           accept;

  // Outputs decode from state and latched command only; accept is internal.
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    sr_en     = 1'b0;
    sr_dir    = 1'b0;
    sr_d      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          accept    = 1'b1;
          state_nxt = (cmd_len == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        sr_en  = 1'b1;
        sr_dir = dir_q;
        sr_d   = data_q[0];
        if ((rem_q == CW'(1)) || abort) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy    = (state != IDLE);
  assign shifted = shifted_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= IDLE;
      dir_q     <= 1'b0;
      data_q    <= '0;
      rem_q     <= '0;
      shifted_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dir_q     <= cmd_dir;
        data_q    <= cmd_data;
        rem_q     <= cmd_len;
        shifted_q <= '0;
      end else if (state == SHIFT) begin
        // Zero fill makes bits beyond cmd_data[MSB-1] shift in as 0.
        data_q    <= {1'b0, data_q[MSB-1:1]};
        rem_q     <= rem_q - CW'(1);
        shifted_q <= shifted_q + CW'(1);
      end
    end
  end

endmodule
